// File: rtl/axi_ram_slave.sv
// axi_ram_slave: burst-capable AXI-style slave backed by an on-chip word RAM.
// Sits downstream of the UDP-to-AXI master. It has independent write and read
// channel FSMs in one clock domain, and the RAM is read-first on collisions.
// Optional feature: define AXI_RAM_BOUND_CHECK_EN to decode-error bursts whose
// start address falls outside the RAM window. Otherwise upper address bits alias.
module axi_ram_slave #(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  SLAVE_WR_ADDR_ID,
  input  logic [31:0] SLAVE_WR_ADDR,
  input  logic [7:0]  SLAVE_WR_ADDR_LEN,
  input  logic [1:0]  SLAVE_WR_ADDR_BURST,
  input  logic        SLAVE_WR_ADDR_VALID,
  output logic        SLAVE_WR_ADDR_READY,
  input  logic [31:0] SLAVE_WR_DATA,
  input  logic [3:0]  SLAVE_WR_STRB,
  input  logic        SLAVE_WR_DATA_LAST,
  input  logic        SLAVE_WR_DATA_VALID,
  output logic        SLAVE_WR_DATA_READY,
  output logic [1:0]  SLAVE_WR_BACK_ID,
  output logic [1:0]  SLAVE_WR_BACK_RESP,
  output logic        SLAVE_WR_BACK_VALID,
  input  logic        SLAVE_WR_BACK_READY,
  input  logic [1:0]  SLAVE_RD_ADDR_ID,
  input  logic [31:0] SLAVE_RD_ADDR,
  input  logic [7:0]  SLAVE_RD_ADDR_LEN,
  input  logic [1:0]  SLAVE_RD_ADDR_BURST,
  input  logic        SLAVE_RD_ADDR_VALID,
  output logic        SLAVE_RD_ADDR_READY,
  output logic [1:0]  SLAVE_RD_BACK_ID,
  output logic [31:0] SLAVE_RD_DATA,
  output logic [1:0]  SLAVE_RD_DATA_RESP,
  output logic        SLAVE_RD_DATA_LAST,
  output logic        SLAVE_RD_DATA_VALID,
  input  logic        SLAVE_RD_DATA_READY
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_q;

  w_state_t          w_state;
  logic [ADDR_W-1:0] w_idx;
  logic [7:0]        w_len;
  logic [7:0]        w_cnt;
  logic              w_incr;
  logic              w_err;
  logic              w_dec;
  logic              w_nowr;
  logic              w_end;
  logic              w_beat_err;
  logic              wr_en;

  r_state_t          r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [7:0]        r_len;
  logic [7:0]        r_cnt;
  logic              r_incr;
  logic              r_zero;
  logic              r_done;
  logic              rd_en;

  logic [ADDR_W-1:0] aw_idx;
  logic [ADDR_W-1:0] ar_idx;
  logic              aw_dec;
  logic              ar_dec;

  // Convert incoming byte addresses into word indices, and flag out-of-window starts.
  always_comb begin
    aw_idx = ADDR_W'((SLAVE_WR_ADDR - BASE_ADDR) >> 2);
    ar_idx = ADDR_W'((SLAVE_RD_ADDR - BASE_ADDR) >> 2);
`ifdef AXI_RAM_BOUND_CHECK_EN
    aw_dec = (SLAVE_WR_ADDR < BASE_ADDR) ||
             (((SLAVE_WR_ADDR - BASE_ADDR) >> (ADDR_W + 2)) != 32'd0);
    ar_dec = (SLAVE_RD_ADDR < BASE_ADDR) ||
             (((SLAVE_RD_ADDR - BASE_ADDR) >> (ADDR_W + 2)) != 32'd0);
`else
    aw_dec = 1'b0;
    ar_dec = 1'b0;
`endif
  end

  // Per-beat write decisions: termination, protocol error and RAM write enable.
  always_comb begin
    w_end      = SLAVE_WR_DATA_LAST || (w_cnt == w_len);
    w_beat_err = SLAVE_WR_DATA_LAST != (w_cnt == w_len);
    wr_en      = (w_state == W_DATA) && SLAVE_WR_DATA_VALID && !w_nowr;
    rd_en      = (r_state == R_DATA) && !r_done &&
                 (!SLAVE_RD_DATA_VALID || SLAVE_RD_DATA_READY);
  end

  // Write channel FSM: address accept, data beats, then a held write response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state             <= W_IDLE;
      w_idx               <= '0;
      w_len               <= 8'd0;
      w_cnt               <= 8'd0;
      w_incr              <= 1'b0;
      w_err               <= 1'b0;
      w_dec               <= 1'b0;
      w_nowr              <= 1'b0;
      SLAVE_WR_ADDR_READY <= 1'b1;
      SLAVE_WR_DATA_READY <= 1'b0;
      SLAVE_WR_BACK_ID    <= 2'b00;
      SLAVE_WR_BACK_RESP  <= RESP_OKAY;
      SLAVE_WR_BACK_VALID <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (SLAVE_WR_ADDR_VALID) begin
            SLAVE_WR_BACK_ID    <= SLAVE_WR_ADDR_ID;
            w_idx               <= aw_idx;
            w_len               <= SLAVE_WR_ADDR_LEN;
            w_cnt               <= 8'd0;
            w_incr              <= (SLAVE_WR_ADDR_BURST == BURST_INCR);
            w_err               <= SLAVE_WR_ADDR_BURST[1];
            w_dec               <= aw_dec;
            w_nowr              <= SLAVE_WR_ADDR_BURST[1] | aw_dec;
            SLAVE_WR_ADDR_READY <= 1'b0;
            SLAVE_WR_DATA_READY <= 1'b1;
            w_state             <= W_DATA;
          end
        end
        W_DATA: begin
          if (SLAVE_WR_DATA_VALID) begin
            w_cnt <= w_cnt + 8'd1;
            if (w_incr) begin
              w_idx <= w_idx + 1'b1;
            end
            if (w_end) begin
              SLAVE_WR_DATA_READY <= 1'b0;
              SLAVE_WR_BACK_VALID <= 1'b1;
              if (w_dec) begin
                SLAVE_WR_BACK_RESP <= RESP_DECERR;
              end else if (w_err || w_beat_err) begin
                SLAVE_WR_BACK_RESP <= RESP_SLVERR;
              end else begin
                SLAVE_WR_BACK_RESP <= RESP_OKAY;
              end
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (SLAVE_WR_BACK_READY) begin
            SLAVE_WR_BACK_VALID <= 1'b0;
            SLAVE_WR_ADDR_READY <= 1'b1;
            w_state             <= W_IDLE;
          end
        end
        default: begin
          w_state <= W_IDLE;
        end
      endcase
    end
  end

  // Read channel FSM: the output register only advances when empty or accepted, so stalls hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state             <= R_IDLE;
      r_idx               <= '0;
      r_len               <= 8'd0;
      r_cnt               <= 8'd0;
      r_incr              <= 1'b0;
      r_zero              <= 1'b0;
      r_done              <= 1'b0;
      SLAVE_RD_ADDR_READY <= 1'b1;
      SLAVE_RD_BACK_ID    <= 2'b00;
      SLAVE_RD_DATA_RESP  <= RESP_OKAY;
      SLAVE_RD_DATA_LAST  <= 1'b0;
      SLAVE_RD_DATA_VALID <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (SLAVE_RD_ADDR_VALID) begin
            SLAVE_RD_BACK_ID    <= SLAVE_RD_ADDR_ID;
            r_idx               <= ar_idx;
            r_len               <= SLAVE_RD_ADDR_LEN;
            r_cnt               <= 8'd0;
            r_done              <= 1'b0;
            r_incr              <= (SLAVE_RD_ADDR_BURST == BURST_INCR);
            r_zero              <= ar_dec | SLAVE_RD_ADDR_BURST[1];
            if (ar_dec) begin
              SLAVE_RD_DATA_RESP <= RESP_DECERR;
            end else if (SLAVE_RD_ADDR_BURST[1]) begin
              SLAVE_RD_DATA_RESP <= RESP_SLVERR;
            end else begin
              SLAVE_RD_DATA_RESP <= RESP_OKAY;
            end
            SLAVE_RD_ADDR_READY <= 1'b0;
            r_state             <= R_DATA;
          end
        end
        R_DATA: begin
          if (rd_en) begin
            SLAVE_RD_DATA_VALID <= 1'b1;
            SLAVE_RD_DATA_LAST  <= (r_cnt == r_len);
            r_done              <= (r_cnt == r_len);
            r_cnt               <= r_cnt + 8'd1;
            if (r_incr) begin
              r_idx <= r_idx + 1'b1;
            end
          end else if (SLAVE_RD_DATA_VALID && SLAVE_RD_DATA_READY) begin
            SLAVE_RD_DATA_VALID <= 1'b0;
            SLAVE_RD_DATA_LAST  <= 1'b0;
            if (SLAVE_RD_DATA_LAST) begin
              SLAVE_RD_ADDR_READY <= 1'b1;
              r_state             <= R_IDLE;
            end
          end
        end
        default: begin
          r_state <= R_IDLE;
        end
      endcase
    end
  end

  // Word RAM with byte-lane writes and a registered read port; a same-cycle read sees old data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (SLAVE_WR_STRB[b]) begin
          mem[w_idx][8*b +: 8] <= SLAVE_WR_DATA[8*b +: 8];
        end
      end
    end
    if (rd_en) begin
      rd_q <= mem[r_idx];
    end
  end

  assign SLAVE_RD_DATA = (SLAVE_RD_DATA_VALID && !r_zero) ? rd_q : 32'h0;

endmodule

// File: tb/tb_axi_ram_slave.sv
// tb_axi_ram_slave: table-driven bench for axi_ram_slave.
// Each table entry is one burst with hand-computed expected responses and data.
// Hand-written sequences cover power-on reset and reset in the middle of a read burst.
module tb_axi_ram_slave;

  localparam logic [31:0] BASE = 32'h0001_0000;

  typedef struct {
    string       name;
    bit          is_wr;
    logic [1:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [3:0]  strb;
    logic [31:0] d0;
    logic [31:0] step;
    int          last_at;
    logic [1:0]  resp;
    logic [31:0] exp_d0;
    logic [31:0] exp_step;
    bit          toggle;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  SLAVE_WR_ADDR_ID = '0;
  logic [31:0] SLAVE_WR_ADDR = '0;
  logic [7:0]  SLAVE_WR_ADDR_LEN = '0;
  logic [1:0]  SLAVE_WR_ADDR_BURST = '0;
  logic        SLAVE_WR_ADDR_VALID = 1'b0;
  logic        SLAVE_WR_ADDR_READY;
  logic [31:0] SLAVE_WR_DATA = '0;
  logic [3:0]  SLAVE_WR_STRB = '0;
  logic        SLAVE_WR_DATA_LAST = 1'b0;
  logic        SLAVE_WR_DATA_VALID = 1'b0;
  logic        SLAVE_WR_DATA_READY;
  logic [1:0]  SLAVE_WR_BACK_ID;
  logic [1:0]  SLAVE_WR_BACK_RESP;
  logic        SLAVE_WR_BACK_VALID;
  logic        SLAVE_WR_BACK_READY = 1'b0;
  logic [1:0]  SLAVE_RD_ADDR_ID = '0;
  logic [31:0] SLAVE_RD_ADDR = '0;
  logic [7:0]  SLAVE_RD_ADDR_LEN = '0;
  logic [1:0]  SLAVE_RD_ADDR_BURST = '0;
  logic        SLAVE_RD_ADDR_VALID = 1'b0;
  logic        SLAVE_RD_ADDR_READY;
  logic [1:0]  SLAVE_RD_BACK_ID;
  logic [31:0] SLAVE_RD_DATA;
  logic [1:0]  SLAVE_RD_DATA_RESP;
  logic        SLAVE_RD_DATA_LAST;
  logic        SLAVE_RD_DATA_VALID;
  logic        SLAVE_RD_DATA_READY = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  axi_ram_slave #(.ADDR_W(10), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .SLAVE_WR_ADDR_ID(SLAVE_WR_ADDR_ID), .SLAVE_WR_ADDR(SLAVE_WR_ADDR),
    .SLAVE_WR_ADDR_LEN(SLAVE_WR_ADDR_LEN), .SLAVE_WR_ADDR_BURST(SLAVE_WR_ADDR_BURST),
    .SLAVE_WR_ADDR_VALID(SLAVE_WR_ADDR_VALID), .SLAVE_WR_ADDR_READY(SLAVE_WR_ADDR_READY),
    .SLAVE_WR_DATA(SLAVE_WR_DATA), .SLAVE_WR_STRB(SLAVE_WR_STRB),
    .SLAVE_WR_DATA_LAST(SLAVE_WR_DATA_LAST), .SLAVE_WR_DATA_VALID(SLAVE_WR_DATA_VALID),
    .SLAVE_WR_DATA_READY(SLAVE_WR_DATA_READY), .SLAVE_WR_BACK_ID(SLAVE_WR_BACK_ID),
    .SLAVE_WR_BACK_RESP(SLAVE_WR_BACK_RESP), .SLAVE_WR_BACK_VALID(SLAVE_WR_BACK_VALID),
    .SLAVE_WR_BACK_READY(SLAVE_WR_BACK_READY),
    .SLAVE_RD_ADDR_ID(SLAVE_RD_ADDR_ID), .SLAVE_RD_ADDR(SLAVE_RD_ADDR),
    .SLAVE_RD_ADDR_LEN(SLAVE_RD_ADDR_LEN), .SLAVE_RD_ADDR_BURST(SLAVE_RD_ADDR_BURST),
    .SLAVE_RD_ADDR_VALID(SLAVE_RD_ADDR_VALID), .SLAVE_RD_ADDR_READY(SLAVE_RD_ADDR_READY),
    .SLAVE_RD_BACK_ID(SLAVE_RD_BACK_ID), .SLAVE_RD_DATA(SLAVE_RD_DATA),
    .SLAVE_RD_DATA_RESP(SLAVE_RD_DATA_RESP), .SLAVE_RD_DATA_LAST(SLAVE_RD_DATA_LAST),
    .SLAVE_RD_DATA_VALID(SLAVE_RD_DATA_VALID), .SLAVE_RD_DATA_READY(SLAVE_RD_DATA_READY)
  );

  // Compare one observed value against its expected value and log any difference.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic vec_t mkW(string name, logic [1:0] id, logic [31:0] off, logic [7:0] len,
                               logic [1:0] burst, logic [3:0] strb, logic [31:0] d0,
                               logic [31:0] step, int last_at, logic [1:0] resp);
    vec_t v;
    v.name = name; v.is_wr = 1'b1; v.id = id; v.addr = BASE + off; v.len = len;
    v.burst = burst; v.strb = strb; v.d0 = d0; v.step = step; v.last_at = last_at;
    v.resp = resp; v.exp_d0 = '0; v.exp_step = '0; v.toggle = 1'b0;
    return v;
  endfunction

  function automatic vec_t mkR(string name, logic [1:0] id, logic [31:0] off, logic [7:0] len,
                               logic [1:0] burst, logic [31:0] exp_d0, logic [31:0] exp_step,
                               logic [1:0] resp, bit toggle);
    vec_t v;
    v.name = name; v.is_wr = 1'b0; v.id = id; v.addr = BASE + off; v.len = len;
    v.burst = burst; v.strb = '0; v.d0 = '0; v.step = '0; v.last_at = 0;
    v.resp = resp; v.exp_d0 = exp_d0; v.exp_step = exp_step; v.toggle = toggle;
    return v;
  endfunction

  // Drive one write burst and check response timing, value and stability.
  task automatic writeBurst(input vec_t v);
    int t;
    int nbeats;
    SLAVE_WR_ADDR_ID = v.id; SLAVE_WR_ADDR = v.addr; SLAVE_WR_ADDR_LEN = v.len;
    SLAVE_WR_ADDR_BURST = v.burst; SLAVE_WR_ADDR_VALID = 1'b1;
    t = 0;
    while (!SLAVE_WR_ADDR_READY && t < 50) begin @(posedge clk); #1; t++; end
    checkOutput({v.name, " aw_ready"}, 32'(SLAVE_WR_ADDR_READY), 32'd1);
    @(posedge clk); #1;
    SLAVE_WR_ADDR_VALID = 1'b0;
    nbeats = ((v.last_at < int'(v.len)) ? v.last_at : int'(v.len)) + 1;
    for (int k = 0; k < nbeats; k++) begin
      SLAVE_WR_DATA = v.d0 + 32'(k) * v.step;
      SLAVE_WR_STRB = v.strb;
      SLAVE_WR_DATA_LAST = (k == v.last_at);
      SLAVE_WR_DATA_VALID = 1'b1;
      t = 0;
      while (!SLAVE_WR_DATA_READY && t < 50) begin @(posedge clk); #1; t++; end
      if (!SLAVE_WR_DATA_READY) checkOutput($sformatf("%s w_ready beat%0d", v.name, k), 32'(SLAVE_WR_DATA_READY), 32'd1);
      @(posedge clk); #1;
    end
    SLAVE_WR_DATA_VALID = 1'b0; SLAVE_WR_DATA_LAST = 1'b0;
    checkOutput({v.name, " b_valid latency"}, 32'(SLAVE_WR_BACK_VALID), 32'd1);
    checkOutput({v.name, " w_ready off"}, 32'(SLAVE_WR_DATA_READY), 32'd0);
    checkOutput({v.name, " b_id"}, 32'(SLAVE_WR_BACK_ID), 32'(v.id));
    checkOutput({v.name, " b_resp"}, 32'(SLAVE_WR_BACK_RESP), 32'(v.resp));
    @(posedge clk); #1;
    checkOutput({v.name, " b_valid held"}, 32'(SLAVE_WR_BACK_VALID), 32'd1);
    checkOutput({v.name, " b_resp held"}, 32'(SLAVE_WR_BACK_RESP), 32'(v.resp));
    SLAVE_WR_BACK_READY = 1'b1;
    @(posedge clk); #1;
    SLAVE_WR_BACK_READY = 1'b0;
    checkOutput({v.name, " b_valid drop"}, 32'(SLAVE_WR_BACK_VALID), 32'd0);
    checkOutput({v.name, " aw_ready back"}, 32'(SLAVE_WR_ADDR_READY), 32'd1);
  endtask

  // Issue one read burst and check latency, per-beat contents, stall stability and beat count.
  task automatic readBurst(input vec_t v);
    int t;
    int k;
    int cyc;
    bit stalled;
    bit tog;
    logic [31:0] snap_d;
    logic snap_l;
    SLAVE_RD_ADDR_ID = v.id; SLAVE_RD_ADDR = v.addr; SLAVE_RD_ADDR_LEN = v.len;
    SLAVE_RD_ADDR_BURST = v.burst; SLAVE_RD_ADDR_VALID = 1'b1;
    t = 0;
    while (!SLAVE_RD_ADDR_READY && t < 50) begin @(posedge clk); #1; t++; end
    checkOutput({v.name, " ar_ready"}, 32'(SLAVE_RD_ADDR_READY), 32'd1);
    @(posedge clk); #1;
    SLAVE_RD_ADDR_VALID = 1'b0;
    checkOutput({v.name, " valid at N+1"}, 32'(SLAVE_RD_DATA_VALID), 32'd0);
    @(posedge clk); #1;
    checkOutput({v.name, " valid at N+2"}, 32'(SLAVE_RD_DATA_VALID), 32'd1);
    k = 0; cyc = 0; stalled = 1'b0; tog = 1'b1; snap_d = '0; snap_l = 1'b0;
    while (k <= int'(v.len) && cyc < 3000) begin
      SLAVE_RD_DATA_READY = v.toggle ? tog : 1'b1;
      if (stalled) begin
        checkOutput($sformatf("%s hold data beat%0d", v.name, k), SLAVE_RD_DATA, snap_d);
        checkOutput($sformatf("%s hold last beat%0d", v.name, k), 32'(SLAVE_RD_DATA_LAST), 32'(snap_l));
        stalled = 1'b0;
      end
      if (SLAVE_RD_DATA_VALID) begin
        if (SLAVE_RD_DATA_READY) begin
          checkOutput($sformatf("%s data beat%0d", v.name, k), SLAVE_RD_DATA, v.exp_d0 + 32'(k) * v.exp_step);
          checkOutput($sformatf("%s resp beat%0d", v.name, k), 32'(SLAVE_RD_DATA_RESP), 32'(v.resp));
          checkOutput($sformatf("%s last beat%0d", v.name, k), 32'(SLAVE_RD_DATA_LAST), 32'(k == int'(v.len)));
          checkOutput($sformatf("%s id beat%0d", v.name, k), 32'(SLAVE_RD_BACK_ID), 32'(v.id));
          k++;
        end else begin
          snap_d = SLAVE_RD_DATA; snap_l = SLAVE_RD_DATA_LAST; stalled = 1'b1;
        end
      end
      tog = ~tog;
      @(posedge clk); #1;
      cyc++;
    end
    SLAVE_RD_DATA_READY = 1'b0;
    checkOutput({v.name, " beat count"}, 32'(k), 32'(int'(v.len) + 1));
    checkOutput({v.name, " valid after"}, 32'(SLAVE_RD_DATA_VALID), 32'd0);
    checkOutput({v.name, " ar_ready after"}, 32'(SLAVE_RD_ADDR_READY), 32'd1);
  endtask

  // Apply one table entry to the appropriate channel.
  task automatic applyStimulus(input vec_t v);
    if (v.is_wr) writeBurst(v);
    else readBurst(v);
  endtask

  // Main sequence: reset checks, the vector table, then a mid-burst reset.
  initial begin
    vecs.push_back(mkW("w_incr4", 2'd1, 32'h10, 8'd3, 2'b01, 4'hF, 32'h1111_1111, 32'h1111_1111, 3, 2'b00));
    vecs.push_back(mkR("r_incr4", 2'd2, 32'h10, 8'd3, 2'b01, 32'h1111_1111, 32'h1111_1111, 2'b00, 1'b0));
    vecs.push_back(mkW("w_fixed3", 2'd3, 32'h20, 8'd2, 2'b00, 4'hF, 32'hA0A0_A0A0, 32'h0101_0101, 2, 2'b00));
    vecs.push_back(mkR("r_fixed", 2'd0, 32'h20, 8'd0, 2'b01, 32'hA2A2_A2A2, 32'h0, 2'b00, 1'b0));
    vecs.push_back(mkW("w_strb3", 2'd1, 32'h20, 8'd0, 2'b01, 4'h3, 32'hDEAD_BEEF, 32'h0, 0, 2'b00));
    vecs.push_back(mkR("r_strb3", 2'd1, 32'h20, 8'd0, 2'b01, 32'hA2A2_BEEF, 32'h0, 2'b00, 1'b0));
    vecs.push_back(mkW("w_seed100", 2'd2, 32'h100, 8'd1, 2'b01, 4'hF, 32'h1234_5678, 32'h1, 1, 2'b00));
    vecs.push_back(mkW("w_badburst", 2'd2, 32'h100, 8'd1, 2'b10, 4'hF, 32'h5555_5555, 32'h0, 1, 2'b10));
    vecs.push_back(mkR("r_after_bad", 2'd3, 32'h100, 8'd1, 2'b01, 32'h1234_5678, 32'h1, 2'b00, 1'b0));
    vecs.push_back(mkR("r_badburst", 2'd3, 32'h100, 8'd2, 2'b11, 32'h0, 32'h0, 2'b10, 1'b0));
    vecs.push_back(mkW("w_early_last", 2'd0, 32'h200, 8'd3, 2'b01, 4'hF, 32'h7000_0000, 32'h1, 1, 2'b10));
    vecs.push_back(mkR("r_early_last", 2'd0, 32'h200, 8'd1, 2'b01, 32'h7000_0000, 32'h1, 2'b00, 1'b0));
    vecs.push_back(mkW("w_no_last", 2'd1, 32'h300, 8'd1, 2'b01, 4'hF, 32'h8000_0000, 32'h1, 99, 2'b10));
    vecs.push_back(mkR("r_no_last", 2'd1, 32'h300, 8'd1, 2'b01, 32'h8000_0000, 32'h1, 2'b00, 1'b0));
    vecs.push_back(mkW("w_wrap", 2'd1, 32'hFFC, 8'd2, 2'b01, 4'hF, 32'hCAFE_0000, 32'h1, 2, 2'b00));
    vecs.push_back(mkR("r_wrap_tog", 2'd2, 32'hFFC, 8'd2, 2'b01, 32'hCAFE_0000, 32'h1, 2'b00, 1'b1));
`ifdef AXI_RAM_BOUND_CHECK_EN
    vecs.push_back(mkR("r_above", 2'd3, 32'h1000, 8'd1, 2'b01, 32'h0, 32'h0, 2'b11, 1'b0));
    vecs.push_back(mkR("r_below", 2'd0, 32'hFFFF_FFFC, 8'd0, 2'b01, 32'h0, 32'h0, 2'b11, 1'b0));
    vecs.push_back(mkW("w_above", 2'd1, 32'h1004, 8'd0, 2'b01, 4'hF, 32'h9999_9999, 32'h0, 0, 2'b11));
    vecs.push_back(mkR("r_word1", 2'd2, 32'h4, 8'd0, 2'b01, 32'hCAFE_0002, 32'h0, 2'b00, 1'b0));
    vecs.push_back(mkW("w_dec_prio", 2'd3, 32'h1000, 8'd0, 2'b10, 4'hF, 32'h7777_7777, 32'h0, 0, 2'b11));
`else
    vecs.push_back(mkR("r_above", 2'd3, 32'h1000, 8'd1, 2'b01, 32'hCAFE_0001, 32'h1, 2'b00, 1'b0));
    vecs.push_back(mkR("r_below", 2'd0, 32'hFFFF_FFFC, 8'd0, 2'b01, 32'hCAFE_0000, 32'h0, 2'b00, 1'b0));
    vecs.push_back(mkW("w_above", 2'd1, 32'h1004, 8'd0, 2'b01, 4'hF, 32'h9999_9999, 32'h0, 0, 2'b00));
    vecs.push_back(mkR("r_word1", 2'd2, 32'h4, 8'd0, 2'b01, 32'h9999_9999, 32'h0, 2'b00, 1'b0));
    vecs.push_back(mkW("w_dec_prio", 2'd3, 32'h1000, 8'd0, 2'b10, 4'hF, 32'h7777_7777, 32'h0, 0, 2'b10));
`endif
    vecs.push_back(mkR("r_word0", 2'd0, 32'h0, 8'd0, 2'b01, 32'hCAFE_0001, 32'h0, 2'b00, 1'b0));
    vecs.push_back(mkW("w_len256", 2'd2, 32'h400, 8'd255, 2'b01, 4'hF, 32'h0, 32'h1, 255, 2'b00));
    vecs.push_back(mkR("r_len256", 2'd3, 32'h400, 8'd255, 2'b01, 32'h0, 32'h1, 2'b00, 1'b0));
    vecs.push_back(mkR("r_len8_tog", 2'd2, 32'h400, 8'd7, 2'b01, 32'h0, 32'h1, 2'b00, 1'b1));

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst aw_ready", 32'(SLAVE_WR_ADDR_READY), 32'd1);
    checkOutput("rst ar_ready", 32'(SLAVE_RD_ADDR_READY), 32'd1);
    checkOutput("rst w_ready", 32'(SLAVE_WR_DATA_READY), 32'd0);
    checkOutput("rst b_valid", 32'(SLAVE_WR_BACK_VALID), 32'd0);
    checkOutput("rst r_valid", 32'(SLAVE_RD_DATA_VALID), 32'd0);
    checkOutput("rst r_data", SLAVE_RD_DATA, 32'd0);
    checkOutput("rst r_last", 32'(SLAVE_RD_DATA_LAST), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
    end

    // Reset while beat 2 of an 8-beat read is on the bus.
    SLAVE_RD_ADDR_ID = 2'd1; SLAVE_RD_ADDR = BASE + 32'h400; SLAVE_RD_ADDR_LEN = 8'd7;
    SLAVE_RD_ADDR_BURST = 2'b01; SLAVE_RD_ADDR_VALID = 1'b1;
    @(posedge clk); #1;
    SLAVE_RD_ADDR_VALID = 1'b0;
    @(posedge clk); #1;
    SLAVE_RD_DATA_READY = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("midrst beat2 data", SLAVE_RD_DATA, 32'd2);
    rst = 1'b1;
    #1;
    checkOutput("midrst r_valid", 32'(SLAVE_RD_DATA_VALID), 32'd0);
    checkOutput("midrst b_valid", 32'(SLAVE_WR_BACK_VALID), 32'd0);
    checkOutput("midrst ar_ready", 32'(SLAVE_RD_ADDR_READY), 32'd1);
    checkOutput("midrst aw_ready", 32'(SLAVE_WR_ADDR_READY), 32'd1);
    checkOutput("midrst r_last", 32'(SLAVE_RD_DATA_LAST), 32'd0);
    SLAVE_RD_DATA_READY = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(mkR("r_after_rst", 2'd3, 32'h410, 8'd3, 2'b01, 32'h4, 32'h1, 2'b00, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/axi_ram_slave.md
Name: axi_ram_slave

Overview:
- Burst-capable AXI-style memory slave that sits directly downstream of the UDP-to-AXI master.
- Consumes the MASTER_* write/read channels produced by the UDP command path and backs them with an on-chip word RAM.
- Serves as the default bus target for the remote-lab host: UDP write commands deposit data, and UDP read commands fetch it back.
- Independent write and read channel FSMs in a single clock domain.

Parameters:
- ADDR_W, 10: log2 of RAM depth in 32-bit words (1024 words = 4 KiB).
- BASE_ADDR, 32'h0000_0000: byte address mapped to word 0; subtracted from incoming addresses.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- SLAVE_WR_ADDR_ID  in  2  write burst ID.
- SLAVE_WR_ADDR  in  32  write start byte address.
- SLAVE_WR_ADDR_LEN  in  8  beats-1.
- SLAVE_WR_ADDR_BURST  in  2  00 FIXED, 01 INCR, others unsupported.
- SLAVE_WR_ADDR_VALID  in  1  write address valid.
- SLAVE_WR_ADDR_READY  out  1  write address ready.
- SLAVE_WR_DATA  in  32  write data.
- SLAVE_WR_STRB  in  4  byte enables; bit i enables byte [8i+7:8i].
- SLAVE_WR_DATA_LAST  in  1  last write beat.
- SLAVE_WR_DATA_VALID  in  1  write data valid.
- SLAVE_WR_DATA_READY  out  1  write data ready.
- SLAVE_WR_BACK_ID  out  2  echoed write ID.
- SLAVE_WR_BACK_RESP  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
- SLAVE_WR_BACK_VALID  out  1  write response valid.
- SLAVE_WR_BACK_READY  in  1  write response ready.
- SLAVE_RD_ADDR_ID  in  2  read burst ID.
- SLAVE_RD_ADDR  in  32  read start byte address.
- SLAVE_RD_ADDR_LEN  in  8  beats-1.
- SLAVE_RD_ADDR_BURST  in  2  read burst type.
- SLAVE_RD_ADDR_VALID  in  1  read address valid.
- SLAVE_RD_ADDR_READY  out  1  read address ready.
- SLAVE_RD_BACK_ID  out  2  echoed read ID.
- SLAVE_RD_DATA  out  32  read data.
- SLAVE_RD_DATA_RESP  out  2  per-beat read response.
- SLAVE_RD_DATA_LAST  out  1  last read beat.
- SLAVE_RD_DATA_VALID  out  1  read data valid.
- SLAVE_RD_DATA_READY  in  1  read data ready.

Behaviour:
- Reset: all outputs 0 except SLAVE_WR_ADDR_READY=1 and SLAVE_RD_ADDR_READY=1.
  - Both FSMs return to IDLE and any in-flight burst is abandoned with no response.
  - RAM contents are not cleared.
- Word index:
  - idx = (ADDR - BASE_ADDR) >> 2; ADDR[1:0] is ignored.
  - RAM uses idx[ADDR_W-1:0].
  - INCR adds 1 per beat and wraps modulo 2^ADDR_W. FIXED holds idx.
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: WR_ADDR_READY=1, WR_DATA_READY=0. An AW handshake latches ID, idx, LEN, BURST, clears beat counter and error flag, then enters W_DATA.
  - W_DATA: WR_ADDR_READY=0, WR_DATA_READY=1. Each handshake writes bytes selected by STRB (STRB=0 writes nothing) and increments the counter.
  - A burst ends on the first beat where LAST=1 or counter==LEN.
  - Error flag is set if LAST=1 on a beat before counter==LEN, or LAST=0 on the counter==LEN beat.
  - Error flag is set if BURST is 10 or 11; beats are then accepted but RAM is not written.
  - W_RESP: BACK_VALID=1, BACK_ID=latched ID, RESP=10 if error flag else 00. Held stable until BACK_READY; the next cycle is W_IDLE.
  - Latency: BACK_VALID rises the cycle after the terminating beat.
- Read FSM, R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: RD_ADDR_READY=1.
  - The AR handshake is at cycle N. Synchronous RAM read; RD_DATA_VALID first high at N+2.
  - With READY held high, beats are back-to-back, LEN+1 beats total. LAST=1 only on beat LEN.
  - While VALID=1 and READY=0: DATA, RESP, LAST and ID are held stable (prefetch/skid register, no dropped beats).
  - Unsupported BURST: DATA=32'h0, RESP=10 on every beat, beat count still LEN+1.
  - RD_ADDR_READY=0 until the last beat's handshake; R_IDLE is entered the cycle after.
- Concurrency:
  - Write and read channels are independent and may be active simultaneously.
  - A read and a write to the same word in the same cycle: the read returns old data (read-first).
- LEN=255 (256 beats) is supported; the counter is 8 bits with no overflow.

Optional Feature:
- Macro AXI_RAM_BOUND_CHECK_EN.
- Defined:
  - A burst whose start address is < BASE_ADDR, or whose (ADDR-BASE_ADDR)>>2 has any bit set at or above ADDR_W, is decode-errored.
  - Writes are suppressed and RESP=11.
  - Reads return DATA=32'h0 with RESP=11 on all beats.
  - DECERR takes priority over SLVERR. Only the start address is checked.
- Not defined: upper bits are ignored (aliasing), and DECERR is never issued.

Test Plan:
- Write INCR, ADDR=0x10, LEN=3, data 0x11111111..0x44444444, STRB=F, LAST on beat 3 -> RESP=00, ID echoed. Read-back with LEN=3 returns the same four words, LAST on beat 3, first VALID at AR+2.
- Write FIXED, ADDR=0x20, LEN=2, data A,B,C -> word 8 = C. Then write to ADDR=0x20 with STRB=0011 and data 0xDEADBEEF -> word reads {C[31:16],16'hBEEF}.
- Write with LEN=3 but LAST asserted on beat 1 -> burst ends after 2 beats, RESP=10, WR_ADDR_READY=1 the cycle after BACK handshake.
- Read INCR, LEN=7, with RD_DATA_READY toggling 1010... -> 8 beats in order, no duplicates or drops, outputs stable while stalled.
- Assert rst mid-read at beat 2 of LEN=7 -> all VALIDs 0 immediately, both ADDR_READYs 1, next AR accepted normally.
- With AXI_RAM_BOUND_CHECK_EN, read ADDR=BASE_ADDR+0x1000 (ADDR_W=10), LEN=1 -> 2 beats, DATA=0, RESP=11. Without the macro, returns word 0 and RESP=00.
